// File: rtl/jetpack_pkg.sv
// Shared geometry, colours and pixel payload type for the jetpack player/renderer.
package jetpack_pkg;

  localparam int unsigned CW       = 11;
  localparam int unsigned BARRY_X0 = 20;
  localparam int unsigned BARRY_W  = 30;
  localparam int unsigned BARRY_H  = 60;
  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned OBS_W    = 20;
  localparam int unsigned Y0_RESET = 210;
  localparam int unsigned Y0_MAX   = SCREEN_H - BARRY_H;

  localparam int unsigned FLAME_X0 = 28;
  localparam int unsigned FLAME_X1 = 41;
  localparam int unsigned FLAME_H  = 12;

  localparam logic [CW-1:0] LANE_TOP [4] = '{11'd40, 11'd140, 11'd240, 11'd340};
  localparam logic [CW-1:0] OBS_LEN  [4] = '{11'd0, 11'd60, 11'd120, 11'd180};

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t COL_BARRY   = '{8'hFF, 8'h80, 8'h00};
  localparam rgb_t COL_OBS     = '{8'hFF, 8'hFF, 8'h00};
  localparam rgb_t COL_BG      = '{8'h00, 8'h00, 8'h40};
  localparam rgb_t COL_BG_OVER = '{8'h80, 8'h00, 8'h00};
  localparam rgb_t COL_FLAME   = '{8'hFF, 8'h20, 8'h00};

  // Inclusive range test on zero-extended coordinates.
  function automatic logic in_span(input logic [CW-1:0] v,
                                   input logic [CW-1:0] lo,
                                   input logic [CW-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/jetpack_player_render_tick_gen.sv
// Physics tick: free-running divider with a registered rising-edge detect on bit TICK_BIT.
module jetpack_player_render_tick_gen #(
  parameter int unsigned TICK_BIT = 20
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  // Bits above TICK_BIT are never observed; 2^32 is a multiple of the tick
  // period, so stopping the counter here keeps the 32-bit wrap behaviour.
  localparam int unsigned DIV_W = TICK_BIT + 1;

  logic [DIV_W-1:0] r_div;
  logic             r_bit_q;
  logic             r_tick;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div   <= '0;
      r_bit_q <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_div   <= r_div + DIV_W'(1);
      r_bit_q <= r_div[TICK_BIT];
      r_tick  <= r_div[TICK_BIT] & ~r_bit_q;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/jetpack_player_render.sv
// Barry motion, obstacle collision and per-pixel colour mux.
// Optional exhaust flame under `define FLAME_EN.
module jetpack_player_render
  import jetpack_pkg::*;
#(
  parameter int unsigned TICK_BIT = 20,
  parameter int unsigned RISE     = 2,
  parameter int unsigned FALL     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       on,
  input  logic [9:0] x,
  input  logic [8:0] y,
  input  logic [9:0] obs1_x,
  input  logic [1:0] obs1_pos,
  input  logic [1:0] obs1_type,
  input  logic [9:0] obs2_x,
  input  logic [1:0] obs2_pos,
  input  logic [1:0] obs2_type,
  output logic [8:0] barry_y0,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic       game_over
);

  logic          w_tick;
  logic [8:0]    r_y0;
  logic [8:0]    w_y0_nxt;
  logic          r_go;
  rgb_t          r_rgb;
  rgb_t          w_rgb_nxt;

  logic [CW-1:0] w_y0_top, w_y0_bot, w_px, w_py;
  logic [9:0]    w_ox   [2];
  logic [1:0]    w_opos [2];
  logic [1:0]    w_otyp [2];
  logic [CW-1:0] w_ol [2], w_or [2], w_ot [2], w_ob [2];
  logic          w_hit, w_on_obs, w_on_barry;

  jetpack_player_render_tick_gen #(.TICK_BIT(TICK_BIT)) u_tick_gen (
    .i_clk  (clk),
    .i_rst  (reset),
    .o_tick (w_tick)
  );

  assign w_ox[0]   = obs1_x;
  assign w_ox[1]   = obs2_x;
  assign w_opos[0] = obs1_pos;
  assign w_opos[1] = obs2_pos;
  assign w_otyp[0] = obs1_type;
  assign w_otyp[1] = obs2_type;

  assign w_y0_top = CW'(r_y0);
  assign w_y0_bot = w_y0_top + CW'(BARRY_H - 1);
  assign w_px     = CW'(x);
  assign w_py     = CW'(y);

  // Obstacle rectangles, bottom clipped to the last visible row.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_ol[i] = CW'(w_ox[i]);
      w_or[i] = w_ol[i] + CW'(OBS_W - 1);
      w_ot[i] = LANE_TOP[w_opos[i]];
      w_ob[i] = w_ot[i] + OBS_LEN[w_otyp[i]] - CW'(1);
      if (w_ob[i] > CW'(SCREEN_H - 1)) w_ob[i] = CW'(SCREEN_H - 1);
    end
  end

  always_comb begin
    w_hit    = 1'b0;
    w_on_obs = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (w_otyp[i] != 2'd0) begin
        if ((w_ol[i] <= CW'(BARRY_X0 + BARRY_W - 1)) && (w_or[i] >= CW'(BARRY_X0)) &&
            (w_ot[i] <= w_y0_bot) && (w_ob[i] >= w_y0_top))
          w_hit = 1'b1;
        if (in_span(w_px, w_ol[i], w_or[i]) && (w_px < CW'(SCREEN_W)) &&
            in_span(w_py, w_ot[i], w_ob[i]))
          w_on_obs = 1'b1;
      end
    end
  end

  assign w_on_barry = in_span(w_px, CW'(BARRY_X0), CW'(BARRY_X0 + BARRY_W - 1)) &&
                      in_span(w_py, w_y0_top, w_y0_bot);

`ifdef FLAME_EN
  logic [CW-1:0] w_fl_top, w_fl_bot;
  logic          w_on_flame;

  assign w_fl_top   = w_y0_top + CW'(BARRY_H);
  assign w_fl_bot   = (w_fl_top + CW'(FLAME_H - 1) > CW'(SCREEN_H - 1)) ?
                      CW'(SCREEN_H - 1) : w_fl_top + CW'(FLAME_H - 1);
  assign w_on_flame = on && !r_go &&
                      in_span(w_px, CW'(FLAME_X0), CW'(FLAME_X1)) &&
                      in_span(w_py, w_fl_top, w_fl_bot);
`endif

  // Lowest priority first; later assignments override.
  always_comb begin
    w_rgb_nxt = r_go ? COL_BG_OVER : COL_BG;
    if (w_on_obs) w_rgb_nxt = COL_OBS;
`ifdef FLAME_EN
    if (w_on_flame) w_rgb_nxt = COL_FLAME;
`endif
    if (w_on_barry) w_rgb_nxt = COL_BARRY;
  end

  // A collision in the same cycle as a tick suppresses the move.
  always_comb begin
    w_y0_nxt = r_y0;
    if (w_tick && !r_go && !w_hit) begin
      if (on)
        w_y0_nxt = (w_y0_top < CW'(RISE)) ? 9'd0 : 9'(w_y0_top - CW'(RISE));
      else
        w_y0_nxt = (w_y0_top + CW'(FALL) > CW'(Y0_MAX)) ? 9'(Y0_MAX)
                                                         : 9'(w_y0_top + CW'(FALL));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_y0  <= 9'(Y0_RESET);
      r_go  <= 1'b0;
      r_rgb <= '0;
    end else begin
      r_y0  <= w_y0_nxt;
      r_go  <= r_go | w_hit;
      r_rgb <= w_rgb_nxt;
    end
  end

  assign barry_y0  = r_y0;
  assign game_over = r_go;
  assign r         = r_rgb.r;
  assign g         = r_rgb.g;
  assign b         = r_rgb.b;

endmodule

// File: tb/tb_jetpack_player_render.sv
// Self-checking bench for jetpack_player_render (TICK_BIT=2, one tick every 8 clocks).
`timescale 1ns/1ps
module tb_jetpack_player_render;

  localparam int TB_TICK = 2;
  localparam int PERIOD  = 2 ** (TB_TICK + 1);
  // Divider restarts at 0; bit TICK_BIT rises at count 2^TICK_BIT, the tick is
  // registered once more, and the move lands on the following edge.
  localparam int MOVE_PHASE = (2 ** TB_TICK + 2) % PERIOD;

  logic       clk = 1'b0;
  logic       reset;
  logic       on;
  logic [9:0] x, obs1_x, obs2_x;
  logic [8:0] y;
  logic [1:0] obs1_pos, obs1_type, obs2_pos, obs2_type;
  logic [8:0] barry_y0;
  logic [7:0] r, g, b;
  logic       game_over;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jetpack_player_render #(.TICK_BIT(TB_TICK), .RISE(2), .FALL(2)) dut (
    .clk(clk), .reset(reset), .on(on), .x(x), .y(y),
    .obs1_x(obs1_x), .obs1_pos(obs1_pos), .obs1_type(obs1_type),
    .obs2_x(obs2_x), .obs2_pos(obs2_pos), .obs2_type(obs2_type),
    .barry_y0(barry_y0), .r(r), .g(g), .b(b), .game_over(game_over)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int obs_bottom(int pos, int typ);
    int bot;
    bot = 40 + 100 * pos + 60 * typ - 1;
    return (bot > 479) ? 479 : bot;
  endfunction

  function automatic bit obs_pixel(int px, int py, int ox, int pos, int typ);
    if (typ == 0 || px > 639) return 1'b0;
    return px >= ox && px <= ox + 19 && py >= 40 + 100 * pos && py <= obs_bottom(pos, typ);
  endfunction

  function automatic bit obs_collide(int y0, int ox, int pos, int typ);
    if (typ == 0) return 1'b0;
    return ox <= 49 && ox + 19 >= 20 && 40 + 100 * pos <= y0 + 59 && obs_bottom(pos, typ) >= y0;
  endfunction

  function automatic logic [23:0] colour(int px, int py, int y0, bit go, bit onv);
    if (px >= 20 && px <= 49 && py >= y0 && py <= y0 + 59) return 24'hFF8000;
`ifdef FLAME_EN
    if (onv && !go && px >= 28 && px <= 41 && py >= y0 + 60 && py <= y0 + 71 && py <= 479)
      return 24'hFF2000;
`endif
    if (obs_pixel(px, py, int'(obs1_x), int'(obs1_pos), int'(obs1_type)) ||
        obs_pixel(px, py, int'(obs2_x), int'(obs2_pos), int'(obs2_type)))
      return 24'hFFFF00;
    if (onv && 1'b0) return 24'h0;
    return go ? 24'h800000 : 24'h000040;
  endfunction

  int          m_y0, m_n;
  bit          m_go;
  logic [23:0] m_rgb;

  always @(posedge clk or posedge reset) begin : model
    bit hit;
    if (reset) begin
      m_y0 = 210; m_go = 1'b0; m_rgb = 24'h0; m_n = 0;
    end else begin
      hit = obs_collide(m_y0, int'(obs1_x), int'(obs1_pos), int'(obs1_type)) ||
            obs_collide(m_y0, int'(obs2_x), int'(obs2_pos), int'(obs2_type));
      m_rgb = colour(int'(x), int'(y), m_y0, m_go, on);
      m_n++;
      if (!m_go && !hit && (m_n % PERIOD) == MOVE_PHASE)
        m_y0 = on ? ((m_y0 - 2 < 0) ? 0 : m_y0 - 2) : ((m_y0 + 2 > 420) ? 420 : m_y0 + 2);
      if (hit) m_go = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("model_y0", 32'(barry_y0), 32'(m_y0));
      chk("model_game_over", 32'(game_over), 32'(m_go));
      chk("model_rgb", 32'({r, g, b}), 32'(m_rgb));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs1_x = 10'd0; obs1_pos = 2'd0; obs1_type = 2'd0;
    obs2_x = 10'd0; obs2_pos = 2'd0; obs2_type = 2'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    int k;
    reset = 1'b1; on = 1'b0; x = 10'd0; y = 9'd0;
    clear_obs();
    step(2);
    chk("reset_y0", 32'(barry_y0), 32'd210);
    chk("reset_go", 32'(game_over), 32'd0);
    chk("reset_rgb", 32'({r, g, b}), 32'h0);
    reset = 1'b0;

    // Pixel colours before the first move lands (edge 6).
    x = 10'd20; y = 9'd210; step(1);
    chk("px_barry_tl", 32'({r, g, b}), 32'hFF8000);
    x = 10'd600; y = 9'd10; step(1);
    chk("px_bg", 32'({r, g, b}), 32'h000040);
    obs1_x = 10'd300; obs1_pos = 2'd1; obs1_type = 2'd2;
    x = 10'd305; y = 9'd200; step(1);
    chk("px_obs", 32'({r, g, b}), 32'hFFFF00);
    x = 10'd320; y = 9'd259; step(1);
    chk("px_obs_right_edge", 32'({r, g, b}), 32'h000040);
    x = 10'd49; y = 9'd269; step(1);
    chk("px_barry_br", 32'({r, g, b}), 32'hFF8000);
    clear_obs();

    // Rise for a while, then reset asynchronously mid-run.
    on = 1'b1;
    for (int i = 0; i < 400; i++) begin
      x = 10'(20 + i % 40); y = 9'(i % 480); step(1);
    end
    #2 reset = 1'b1;
    #1;
    chk("async_reset_y0", 32'(barry_y0), 32'd210);
    chk("async_reset_go", 32'(game_over), 32'd0);
    chk("async_reset_rgb", 32'({r, g, b}), 32'h0);
    step(1);
    reset = 1'b0;
    step(5);
    chk("div_restart_hold", 32'(barry_y0), 32'd210);
    step(1);
    chk("div_restart_move", 32'(barry_y0), 32'd208);

    // 110 ticks of thrust: saturate at the top.
    for (int i = 0; i < 880; i++) begin
      x = 10'(20 + i % 40); y = 9'(i % 480); step(1);
    end
    chk("rise_sat_top", 32'(barry_y0), 32'd0);

    // Fall back down to 418, then one tick to the floor and hold.
    on = 1'b0;
    k = 0;
    while (m_y0 != 418 && k < 3000) begin
      x = 10'(20 + k % 40); y = 9'(k % 480); step(1); k++;
    end
    chk("fall_reach_418", 32'(barry_y0), 32'd418);
    step(8);
    chk("fall_one_tick_420", 32'(barry_y0), 32'd420);
    step(40);
    chk("fall_sat_420", 32'(barry_y0), 32'd420);

    // Near misses and absent obstacles must not collide; a vertical overlap must.
    do_reset();
    obs1_x = 10'd0;  obs1_pos = 2'd2; obs1_type = 2'd1;
    obs2_x = 10'd50; obs2_pos = 2'd2; obs2_type = 2'd1;
    x = 10'd10; y = 9'd250; step(3);
    chk("adjacent_no_hit", 32'(game_over), 32'd0);
    chk("px_obs_left", 32'({r, g, b}), 32'hFFFF00);
    clear_obs();
    obs1_x = 10'd30; obs1_pos = 2'd2; obs1_type = 2'd0; step(1);
    chk("absent_no_hit", 32'(game_over), 32'd0);
    obs1_type = 2'd3; obs1_pos = 2'd0; step(1);
    chk("lane0_long_hit", 32'(game_over), 32'd1);

    // Collision freezes Barry and reddens the background.
    do_reset();
    obs1_x = 10'd40; obs1_pos = 2'd2; obs1_type = 2'd1;
    on = 1'b1; x = 10'd600; y = 9'd10; step(1);
    chk("collide_go", 32'(game_over), 32'd1);
    chk("collide_rgb_prev", 32'({r, g, b}), 32'h000040);
    step(1);
    chk("over_bg", 32'({r, g, b}), 32'h800000);
    step(30);
    chk("over_frozen", 32'(barry_y0), 32'd210);
    clear_obs(); on = 1'b0; step(20);
    chk("over_sticky", 32'(game_over), 32'd1);
    chk("over_frozen2", 32'(barry_y0), 32'd210);

`ifdef FLAME_EN
    do_reset();
    on = 1'b1; x = 10'd30; y = 9'd275; step(1);
    chk("flame_on", 32'({r, g, b}), 32'hFF2000);
    on = 1'b0; step(1);
    chk("flame_off", 32'({r, g, b}), 32'h000040);
`endif

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
